// File: rtl/multicycle_ctrl_if.sv
// Instruction-memory fetch handshake between the multicycle controller (master)
// and instruction memory (slave).
interface multicycle_ctrl_if;
  logic        imem_req;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH -> DECODE -> EXEC -> WB, sticky HALT on illegal or fetch timeout.
// Optional retired-instruction counter enabled by defining MULTICYCLE_CTRL_RETIRE_CNT_EN.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.master   imem,
  output logic [31:0]         ir,
  output logic                pc_en,
  output logic                reg_write,
  output logic [2:0]          alu_op,
  output logic                halt,
  output logic [31:0]         retire_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_NONE = 3'b111;

  localparam logic [6:0] OPCODE_OP    = 7'b0110011;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  timeout_cnt;
  logic        dec_legal;
  logic [2:0]  dec_op;

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = ALU_NONE;
    if (ir[6:0] == OPCODE_OP) begin
      case ({ir[31:25], ir[14:12]})
        10'b0000000_000: begin dec_legal = 1'b1; dec_op = ALU_ADD; end
        10'b0100000_000: begin dec_legal = 1'b1; dec_op = ALU_SUB; end
        10'b0000000_111: begin dec_legal = 1'b1; dec_op = ALU_AND; end
        10'b0000000_110: begin dec_legal = 1'b1; dec_op = ALU_OR;  end
        10'b0000000_010: begin dec_legal = 1'b1; dec_op = ALU_SLT; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A valid word on the last allowed FETCH cycle still wins over the timeout.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = FETCH;
      FETCH: begin
        if (imem.imem_valid) begin
          next_state = DECODE;
        end else if (timeout_cnt == TIMEOUT_LAST) begin
          next_state = HALT;
        end
      end
      DECODE:  next_state = dec_legal ? EXEC : HALT;
      EXEC:    next_state = WB;
      WB:      next_state = FETCH;
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req = (state == FETCH);
    halt          = (state == HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir          <= '0;
      timeout_cnt <= '0;
      alu_op      <= ALU_NONE;
      reg_write   <= 1'b0;
      pc_en       <= 1'b0;
    end else begin
      if (state == FETCH) begin
        if (imem.imem_valid) begin
          ir          <= imem.imem_rdata;
          timeout_cnt <= '0;
        end else begin
          timeout_cnt <= timeout_cnt + 8'd1;
        end
      end
      if (state == DECODE) begin
        alu_op <= dec_op;
      end
      // Any entry into HALT, illegal decode or fetch timeout, parks the ALU select.
      if (next_state == HALT) begin
        alu_op <= ALU_NONE;
      end
      reg_write <= (next_state == WB);
      pc_en     <= (next_state == WB);
    end
  end

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else if (state == WB) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_q;
`else
  assign retire_cnt = '0;
`endif

endmodule
